fp_mul_pipe: RTL and testbench
==============================

Name: fp_mul_pipe

Overview:
- Parametrised, fully pipelined IEEE-754 style multiplier.
- Generalises the fixed single-precision unit in three ways:
  - exponent and fraction widths are parameters;
  - operands are accepted every cycle under a valid/ready handshake with backpressure;
  - a user tag travels with each operation.
- Sits between the FPU operand issue logic and the result writeback arbiter.
- Subnormals are flushed to zero on input and output.

Parameters:
- EXP_W, 8, exponent field width
- FRAC_W, 23, stored fraction width (hidden bit excluded)
- TAG_W, 4, width of the opaque tag carried with each operation
- Derived: W = 1+EXP_W+FRAC_W; BIAS = 2^(EXP_W-1)-1

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  pipeline can accept this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_rm  in  3  rounding mode, sampled with operands
- in_tag  in  TAG_W  user tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  W  result
- out_tag  out  TAG_W  tag of result
- out_flags  out  5  {inv, dz(always 0), ov, un, inexact}

Behaviour:
- Reset: all stage valids = 0; out_valid = 0; out_res = 0; out_tag = 0; out_flags = 0; in_ready = 1 once rst deasserts.
- Reset asserted mid-operation: all in-flight operations are discarded and nothing is emitted.
- Pipeline structure: 3 stages, latency 3 cycles from the accept edge to out_valid.
  - S1: unpack, classify, sign = a.s^b.s, full (FRAC_W+1)x(FRAC_W+1) mantissa product registered.
  - S2: normalise (shift right 1 if product MSB set, exp+1); exponent = ea+eb-BIAS computed in EXP_W+2 signed bits; guard/sticky formed.
  - S3: round, overflow/underflow resolution, pack, flags.
- Handshake:
  - stall = out_valid & ~out_ready; when stalled, every stage holds and in_ready = 0.
  - Bubbles are not compressed.
  - Throughput is 1 operation per cycle with out_ready held high.
  - Operation accepted iff in_valid & in_ready on the clock edge.
- Rounding-mode encoding (package): RNE=0, RZ=1, RD=2, RU=3, RNA=4. Codes 5-7 behave as RNE.
- Rounding increment rules, with g = guard bit, t = sticky, l = lsb:
  - RNE: g&(t|l).
  - RNA: g.
  - RZ: 0.
  - RU: ~sign&(g|t).
  - RD: sign&(g|t).
  - A mantissa carry-out increments the exponent.
- Flag rules:
  - inexact = g|t, or any ov/un case.
- Special operands, resolved in S1 and carried as a forced result; priority top-down:
  1. Any NaN: canonical qNaN (exp all-ones, frac MSB set, sign 0). inv = 1 if either NaN is signalling.
  2. Inf x zero (either order): qNaN, inv = 1.
  3. Inf x finite or inf x inf: inf with sign.
  4. Zero or subnormal operand: zero with sign, no flags.
- Overflow (rounded biased exponent >= 2^EXP_W-1): ov = 1, inexact = 1. Result by mode:
  - RNE/RNA: inf.
  - RZ: max finite.
  - RU: +inf if positive, else -max finite.
  - RD: -inf if negative, else +max finite.
- Underflow (biased exponent <= 0 after rounding): signed zero, un = 1, inexact = 1.
- Exact results raise no flags.
- out_tag is always the tag of the operation whose result is presented.

Decomposition:
- Package fp_pkg holds:
  - rounding-mode constants;
  - flag bit indices;
  - class enum {ZERO, NORM, INF, QNAN, SNAN};
  - functions for canonical qNaN, max-finite and inf construction parameterised by EXP_W/FRAC_W.
- Sub-module fp_mul_mant: unsigned (FRAC_W+1)-bit mantissa multiplier with a registered output. It forms the S1 product register and has an enable input tied to ~stall.

Test Plan:
- 0x40400000 x 0x40200000, RNE, tag 5 -> out_res 0x40F00000, flags 0, tag 5, out_valid exactly 3 cycles after accept. 0xC0400000 x 0x40200000 -> 0xC0F00000.
- Tie rounding: 0x3FA00000 x 0x3F800002.
  - RNE -> 0x3FA00002, inexact=1.
  - RNA -> 0x3FA00003.
  - RZ -> 0x3FA00002.
- Specials and underflow:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000, inv=1.
  - 0x7F800001 x 0x3F800000 -> 0x7FC00000, inv=1.
  - 0x00800000 x 0x3E800000 -> 0x00000000, un=1, inexact=1.
- Overflow: 0x7F7FFFFF x 0x40000000.
  - RNE -> 0x7F800000, ov=1, inexact=1.
  - RZ -> 0x7F7FFFFF.
  - Negated operand in RU -> 0xFF7FFFFF.
- Backpressure: stream 8 ops back-to-back while out_ready toggles 1,0,0,1,...
  - in_ready falls in the same cycle as out_ready is low with out_valid high.
  - No result is lost or duplicated; tags come out in order 0..7.
- Reset mid-operation: 3 ops in flight, rst pulsed low for 1 cycle.
  - out_valid is 0 immediately and stays 0 until new input.
  - The next op completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared floating-point definitions: rounding-mode codes,
//               exception-flag bit positions, operand classes and builders
//               for the canonical special encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

  // Rounding modes; unused codes 5-7 fall back to round-to-nearest-even
  localparam logic [2:0] c_rm_rne = 3'd0;
  localparam logic [2:0] c_rm_rz  = 3'd1;
  localparam logic [2:0] c_rm_rd  = 3'd2;
  localparam logic [2:0] c_rm_ru  = 3'd3;
  localparam logic [2:0] c_rm_rna = 3'd4;

  // Bit positions inside the 5-bit exception flag vector
  localparam int c_flag_nx  = 0;
  localparam int c_flag_un  = 1;
  localparam int c_flag_ov  = 2;
  localparam int c_flag_dz  = 3;
  localparam int c_flag_inv = 4;

  // Widest encoding the builder functions can produce
  localparam int c_fp_max_w = 128;
  localparam logic [c_fp_max_w-1:0] c_one = {{(c_fp_max_w-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    FC_ZERO = 3'd0,
    FC_NORM = 3'd1,
    FC_INF  = 3'd2,
    FC_QNAN = 3'd3,
    FC_SNAN = 3'd4
  } fp_class_e;

  // Positive infinity: exponent all ones, fraction zero
  function automatic logic [c_fp_max_w-1:0] fp_inf_bits(input int exp_w, input int frac_w);
    return ((c_one << exp_w) - c_one) << frac_w;
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, fraction MSB only
  function automatic logic [c_fp_max_w-1:0] fp_qnan_bits(input int exp_w, input int frac_w);
    return fp_inf_bits(exp_w, frac_w) | (c_one << (frac_w - 1));
  endfunction

  // Largest positive finite value: exponent all ones minus one, fraction all ones
  function automatic logic [c_fp_max_w-1:0] fp_max_bits(input int exp_w, input int frac_w);
    return (((c_one << exp_w) - (c_one << 1)) << frac_w) | ((c_one << frac_w) - c_one);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mul_mant.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_mant
// Description : Unsigned mantissa multiplier with a registered full-width
//               product; holds its value while the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_mant #(
  parameter int M_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_en,
  input  logic [M_W-1:0]     i_a,
  input  logic [M_W-1:0]     i_b,
  output logic [2*M_W-1:0]   o_prod
);

  logic [2*M_W-1:0] r_prod;

  // Capture the full double-width product whenever the pipeline advances
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= {{M_W{1'b0}}, i_a} * {{M_W{1'b0}}, i_b};
    end
  end

  assign o_prod = r_prod;

endmodule
`default_nettype wire

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pipe
// Description : Three-stage pipelined floating-point multiplier with
//               valid/ready handshake, tag passthrough, flush-to-zero and
//               all five rounding modes.
//               S1 unpack/classify/product, S2 normalise, S3 round/pack.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_pipe import fp_pkg::*; #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1+EXP_W+FRAC_W-1:0]    in_a,
  input  logic [1+EXP_W+FRAC_W-1:0]    in_b,
  input  logic [2:0]                   in_rm,
  input  logic [TAG_W-1:0]             in_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [1+EXP_W+FRAC_W-1:0]    out_res,
  output logic [TAG_W-1:0]             out_tag,
  output logic [4:0]                   out_flags
);

  localparam int W   = 1 + EXP_W + FRAC_W;
  localparam int M_W = FRAC_W + 1;
  localparam int P_W = 2 * M_W;
  localparam int E_W = EXP_W + 2;

  localparam logic signed [E_W-1:0] c_bias = E_W'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] c_emax = E_W'((2 ** EXP_W) - 1);
  localparam logic [W-1:0] c_qnan  = W'(fp_qnan_bits(EXP_W, FRAC_W));
  localparam logic [W-1:0] c_inf_p = W'(fp_inf_bits(EXP_W, FRAC_W));
  localparam logic [W-1:0] c_max_p = W'(fp_max_bits(EXP_W, FRAC_W));

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [FRAC_W-1:0] f);
    if (e == '0)                return FC_ZERO;  // zero and subnormal flush together
    else if (e != '1)           return FC_NORM;
    else if (f == '0)           return FC_INF;
    else if (f[FRAC_W-1])       return FC_QNAN;
    else                        return FC_SNAN;
  endfunction

  // ---------------------------------------------------------------- handshake
  logic w_stall;
  logic w_en;
  logic r_out_valid;

  assign w_stall  = r_out_valid & ~out_ready;
  assign w_en     = ~w_stall;
  assign in_ready = w_en;

  // ---------------------------------------------------------------- stage 1
  fp_class_e          w_ca;
  fp_class_e          w_cb;
  logic               w_sign1;
  logic               w_force1;
  logic               w_finv1;
  logic [W-1:0]       w_fres1;
  logic [M_W-1:0]     w_ma;
  logic [M_W-1:0]     w_mb;

  assign w_ca    = classify(in_a[W-2 -: EXP_W], in_a[FRAC_W-1:0]);
  assign w_cb    = classify(in_b[W-2 -: EXP_W], in_b[FRAC_W-1:0]);
  assign w_sign1 = in_a[W-1] ^ in_b[W-1];
  assign w_ma    = {1'b1, in_a[FRAC_W-1:0]};
  assign w_mb    = {1'b1, in_b[FRAC_W-1:0]};

  // Resolve special operands up front; the forced result bypasses the datapath
  always_comb begin
    w_force1 = 1'b1;
    w_finv1  = 1'b0;
    w_fres1  = '0;
    if (w_ca == FC_QNAN || w_ca == FC_SNAN || w_cb == FC_QNAN || w_cb == FC_SNAN) begin
      w_fres1 = c_qnan;
      w_finv1 = (w_ca == FC_SNAN) || (w_cb == FC_SNAN);
    end else if ((w_ca == FC_INF && w_cb == FC_ZERO) || (w_ca == FC_ZERO && w_cb == FC_INF)) begin
      w_fres1 = c_qnan;
      w_finv1 = 1'b1;
    end else if (w_ca == FC_INF || w_cb == FC_INF) begin
      w_fres1 = {w_sign1, c_inf_p[W-2:0]};
    end else if (w_ca == FC_ZERO || w_cb == FC_ZERO) begin
      w_fres1 = {w_sign1, {(W-1){1'b0}}};
    end else begin
      w_force1 = 1'b0;
    end
  end

  logic [P_W-1:0] w_prod;

  fp_mul_mant #(
    .M_W (M_W)
  ) u_mant (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_a    (w_ma),
    .i_b    (w_mb),
    .o_prod (w_prod)
  );

  logic               r1_valid;
  logic               r1_sign;
  logic [EXP_W-1:0]   r1_ea;
  logic [EXP_W-1:0]   r1_eb;
  logic               r1_force;
  logic               r1_finv;
  logic [W-1:0]       r1_fres;
  logic [2:0]         r1_rm;
  logic [TAG_W-1:0]   r1_tag;

  // Stage 1 register: operand side-band alongside the product register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_ea    <= '0;
      r1_eb    <= '0;
      r1_force <= 1'b0;
      r1_finv  <= 1'b0;
      r1_fres  <= '0;
      r1_rm    <= '0;
      r1_tag   <= '0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      r1_sign  <= w_sign1;
      r1_ea    <= in_a[W-2 -: EXP_W];
      r1_eb    <= in_b[W-2 -: EXP_W];
      r1_force <= w_force1;
      r1_finv  <= w_finv1;
      r1_fres  <= w_fres1;
      r1_rm    <= in_rm;
      r1_tag   <= in_tag;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic                   w_msb;
  logic signed [E_W-1:0]  w_exp2;
  logic [M_W-1:0]         w_mant2;
  logic                   w_g2;
  logic                   w_t2;

  // Product lies in [1,4): renormalise to [1,2) and collect the discarded bits
  assign w_msb   = w_prod[P_W-1];
  assign w_exp2  = $signed({2'b00, r1_ea}) + $signed({2'b00, r1_eb}) - c_bias
                 + $signed({{(E_W-1){1'b0}}, w_msb});
  assign w_mant2 = w_msb ? w_prod[P_W-1 -: M_W] : w_prod[P_W-2 -: M_W];
  assign w_g2    = w_msb ? w_prod[M_W-1] : w_prod[M_W-2];
  assign w_t2    = w_msb ? (|w_prod[M_W-2:0]) : (|w_prod[M_W-3:0]);

  logic                   r2_valid;
  logic                   r2_sign;
  logic signed [E_W-1:0]  r2_exp;
  logic [M_W-1:0]         r2_mant;
  logic                   r2_g;
  logic                   r2_t;
  logic                   r2_force;
  logic                   r2_finv;
  logic [W-1:0]           r2_fres;
  logic [2:0]             r2_rm;
  logic [TAG_W-1:0]       r2_tag;

  // Stage 2 register: normalised mantissa, unbiased-sum exponent, guard/sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r2_valid <= 1'b0;
      r2_sign  <= 1'b0;
      r2_exp   <= '0;
      r2_mant  <= '0;
      r2_g     <= 1'b0;
      r2_t     <= 1'b0;
      r2_force <= 1'b0;
      r2_finv  <= 1'b0;
      r2_fres  <= '0;
      r2_rm    <= '0;
      r2_tag   <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_sign  <= r1_sign;
      r2_exp   <= w_exp2;
      r2_mant  <= w_mant2;
      r2_g     <= w_g2;
      r2_t     <= w_t2;
      r2_force <= r1_force;
      r2_finv  <= r1_finv;
      r2_fres  <= r1_fres;
      r2_rm    <= r1_rm;
      r2_tag   <= r1_tag;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic                   w_inc;
  logic [M_W:0]           w_mant_r;
  logic                   w_carry;
  logic [FRAC_W-1:0]      w_frac3;
  logic signed [E_W-1:0]  w_exp3;
  logic                   w_of;
  logic                   w_uf;
  logic [W-1:0]           w_res3;
  logic [4:0]             w_flags3;

  // Rounding increment decision per mode
  always_comb begin
    w_inc = 1'b0;
    case (r2_rm)
      c_rm_rz:  w_inc = 1'b0;
      c_rm_rd:  w_inc = r2_sign & (r2_g | r2_t);
      c_rm_ru:  w_inc = ~r2_sign & (r2_g | r2_t);
      c_rm_rna: w_inc = r2_g;
      default:  w_inc = r2_g & (r2_t | r2_mant[0]);
    endcase
  end

  assign w_mant_r = {1'b0, r2_mant} + {{M_W{1'b0}}, w_inc};
  assign w_carry  = w_mant_r[M_W];
  assign w_frac3  = w_carry ? w_mant_r[FRAC_W:1] : w_mant_r[FRAC_W-1:0];
  assign w_exp3   = r2_exp + $signed({{(E_W-1){1'b0}}, w_carry});
  assign w_of     = (w_exp3 >= c_emax);
  assign w_uf     = w_exp3[E_W-1] || (w_exp3 == '0);

  // Final result selection: forced special, overflow, underflow or normal pack
  always_comb begin
    w_res3   = '0;
    w_flags3 = '0;
    if (r2_force) begin
      w_res3               = r2_fres;
      w_flags3[c_flag_inv] = r2_finv;
    end else if (w_of) begin
      w_flags3[c_flag_ov] = 1'b1;
      w_flags3[c_flag_nx] = 1'b1;
      case (r2_rm)
        c_rm_rz: w_res3 = {r2_sign, c_max_p[W-2:0]};
        c_rm_ru: w_res3 = r2_sign ? {1'b1, c_max_p[W-2:0]} : {1'b0, c_inf_p[W-2:0]};
        c_rm_rd: w_res3 = r2_sign ? {1'b1, c_inf_p[W-2:0]} : {1'b0, c_max_p[W-2:0]};
        default: w_res3 = {r2_sign, c_inf_p[W-2:0]};
      endcase
    end else if (w_uf) begin
      w_res3              = {r2_sign, {(W-1){1'b0}}};
      w_flags3[c_flag_un] = 1'b1;
      w_flags3[c_flag_nx] = 1'b1;
    end else begin
      w_res3              = {r2_sign, w_exp3[EXP_W-1:0], w_frac3};
      w_flags3[c_flag_nx] = r2_g | r2_t;
    end
  end

  logic [W-1:0]       r_out_res;
  logic [TAG_W-1:0]   r_out_tag;
  logic [4:0]         r_out_flags;

  // Output register: holds the presented result until the consumer takes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_res   <= '0;
      r_out_tag   <= '0;
      r_out_flags <= '0;
    end else if (w_en) begin
      r_out_valid <= r2_valid;
      r_out_res   <= w_res3;
      r_out_tag   <= r2_tag;
      r_out_flags <= w_flags3;
    end
  end

  assign out_valid = r_out_valid;
  assign out_res   = r_out_res;
  assign out_tag   = r_out_tag;
  assign out_flags = r_out_flags;

endmodule
`default_nettype wire

// File: tb/tb_fp_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_pipe
// Description : Directed self-checking bench for fp_mul_pipe (single
//               precision): arithmetic vectors, specials, backpressure and
//               mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_rm;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
  logic [3:0]  out_tag;
  logic [4:0]  out_flags;

  fp_mul_pipe #(
    .EXP_W  (8),
    .FRAC_W (23),
    .TAG_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_rm     (in_rm),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_tag   (out_tag),
    .out_flags (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ------------------------------------------------------------ checking
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ vectors
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] res;
    logic [4:0]  fl;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  initial begin
    // flags = {inv, dz, ov, un, nx}
    vecs[0]  = '{32'h40400000, 32'h40200000, 3'd0, 32'h40F00000, 5'h00}; // 3*2.5
    vecs[1]  = '{32'hC0400000, 32'h40200000, 3'd0, 32'hC0F00000, 5'h00}; // -3*2.5
    vecs[2]  = '{32'h3FA00000, 32'h3F800002, 3'd0, 32'h3FA00002, 5'h01}; // tie RNE
    vecs[3]  = '{32'h3FA00000, 32'h3F800002, 3'd4, 32'h3FA00003, 5'h01}; // tie RNA
    vecs[4]  = '{32'h3FA00000, 32'h3F800002, 3'd1, 32'h3FA00002, 5'h01}; // tie RZ
    vecs[5]  = '{32'h3FA00000, 32'h3F800002, 3'd3, 32'h3FA00003, 5'h01}; // tie RU +
    vecs[6]  = '{32'h3FA00000, 32'h3F800002, 3'd2, 32'h3FA00002, 5'h01}; // tie RD +
    vecs[7]  = '{32'h3FA00000, 32'h3F800002, 3'd7, 32'h3FA00002, 5'h01}; // code 7 = RNE
    vecs[8]  = '{32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 5'h10}; // inf*0
    vecs[9]  = '{32'h7F800001, 32'h3F800000, 3'd0, 32'h7FC00000, 5'h10}; // sNaN
    vecs[10] = '{32'h00800000, 32'h3E800000, 3'd0, 32'h00000000, 5'h03}; // underflow
    vecs[11] = '{32'h7F7FFFFF, 32'h40000000, 3'd0, 32'h7F800000, 5'h05}; // ovf RNE
    vecs[12] = '{32'h7F7FFFFF, 32'h40000000, 3'd1, 32'h7F7FFFFF, 5'h05}; // ovf RZ
    vecs[13] = '{32'hFF7FFFFF, 32'h40000000, 3'd3, 32'hFF7FFFFF, 5'h05}; // ovf RU neg
    vecs[14] = '{32'hFF7FFFFF, 32'h40000000, 3'd2, 32'hFF800000, 5'h05}; // ovf RD neg
    vecs[15] = '{32'h80000000, 32'h40000000, 3'd0, 32'h80000000, 5'h00}; // -0*2
    vecs[16] = '{32'hFF800000, 32'h40000000, 3'd0, 32'hFF800000, 5'h00}; // -inf*2
    vecs[17] = '{32'h7FC00000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'h00}; // qNaN*inf
    vecs[18] = '{32'h00000000, 32'h7F800000, 3'd0, 32'h7FC00000, 5'h10}; // 0*inf
    vecs[19] = '{32'h00000001, 32'h40000000, 3'd0, 32'h00000000, 5'h00}; // subnormal in
    vecs[20] = '{32'hBFA00000, 32'h3F800002, 3'd2, 32'hBFA00003, 5'h01}; // tie RD -
    vecs[21] = '{32'hBFA00000, 32'h3F800002, 3'd3, 32'hBFA00002, 5'h01}; // tie RU -
    vecs[22] = '{32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 5'h00}; // 1*1
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct {
    logic [31:0] res;
    logic [4:0]  fl;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  bit   mon_en   = 1'b0;
  bit   lat_chk  = 1'b0;
  bit   bp_en    = 1'b0;
  int   n_rx     = 0;
  int   n_stall  = 0;
  int   bp_k     = 0;

  // Consumer backpressure pattern 1,0,0 repeating
  always @(negedge clk) begin
    if (bp_en) begin
      out_ready = (bp_k % 3 == 0);
      bp_k++;
    end
  end

  // Output monitor, sampled mid-cycle after inputs have settled
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (mon_en) begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (out_valid && !out_ready) n_stall++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check($sformatf("res tag%0d", e.tag), out_res, e.res);
          check($sformatf("flags tag%0d", e.tag), out_flags, e.fl);
          check("tag_order", out_tag, e.tag);
          if (lat_chk) check($sformatf("latency tag%0d", e.tag), 64'(cyc - e.acc), 64'd2);
          n_rx++;
        end
      end
    end
  end

  // Present one operation and hold it until it is accepted
  task automatic send(input vec_t v, input logic [3:0] tg);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = v.a;
    in_b     = v.b;
    in_rm    = v.rm;
    in_tag   = tg;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
    end else begin
      sb.push_back('{v.res, v.fl, tg, cyc + 1});
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------ sequence
  initial begin
    int n0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_rm     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_res",   out_res,   32'h0);
    check("rst_out_tag",   out_tag,   4'h0);
    check("rst_out_flags", out_flags, 5'h0);
    rst = 1'b1;
    #1 check("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, back-to-back, consumer always ready
    mon_en  = 1'b1;
    lat_chk = 1'b1;
    for (int i = 0; i < NV; i++) send(vecs[i], 4'(i));
    idle();
    drain();

    // Backpressure stream of 8 with tags 0..7
    lat_chk = 1'b0;
    n0      = n_rx;
    bp_k    = 0;
    bp_en   = 1'b1;
    for (int i = 0; i < 8; i++) send(vecs[i], 4'(i));
    idle();
    drain();
    bp_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    check("bp_result_count", 64'(n_rx - n0), 64'd8);
    check("bp_stall_seen", (n_stall > 0), 1'b1);

    // Reset with three operations in flight and result held
    mon_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = vecs[i].a;
      in_b     = vecs[i].b;
      in_rm    = vecs[i].rm;
      in_tag   = 4'(10 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_res",   out_res,   32'h0);
    check("midrst_out_tag",   out_tag,   4'h0);
    check("midrst_out_flags", out_flags, 5'h0);
    @(negedge clk);
    rst       = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check($sformatf("post_rst_quiet%0d", i), out_valid, 1'b0);
    end
    mon_en  = 1'b1;
    lat_chk = 1'b1;
    send(vecs[0], 4'd9);
    idle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
